mp_addsub_seq: RTL

Parametrised, limb-serial multi-precision adder/subtractor for the Montgomery datapath and the next generation of the single-cycle wide adder. It processes a WIDTH-bit operation one LIMB-bit slice per clock with a registered inter-limb carry. It supports add, subtract and add-then-halve, plus an accumulate option that feeds back the previous result as operand B. A start/done handshake connects it to the Montgomery controller; carry and zero flags are held alongside the result.

---
 rtl/mp_addsub_seq.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mp_addsub_seq.sv
// mp_addsub_seq: limb-serial multi-precision add / subtract / add-then-halve unit
//
// One LIMB-bit slice of a WIDTH-bit operation is processed per clock, with the
// inter-limb carry held in a register. Operands are zero-extended to NLIMB*LIMB
// bits internally.
//
// Ports:
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   start      request, accepted only in IDLE
//   mode       00 add, 01 a-b, 10 add-then-shift-right-1, 11 add
//   use_acc    sampled with start: operand B is the current result register
//   in_a/in_b  operands, sampled on the accepting edge
//   busy       high from the accepting edge until done
//   done       one-cycle pulse, result valid
//   result     result register, held until the next accepted start
//   carry_out  add: carry into bit WIDTH; sub: 1 = no borrow; shift: bit shifted out
//   zero       result == 0, updated with done
//
// Build option: define MP_ADDSUB_SHIFT_EN to enable mode 10 (SHIFT state);
// otherwise mode 10 behaves exactly like an add.
module mp_addsub_seq #(
  parameter int WIDTH = 512,
  parameter int LIMB  = 128
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             use_acc,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero
);
  localparam int NLIMB = (WIDTH + LIMB - 1) / LIMB;
  localparam int EW    = NLIMB * LIMB;
  localparam int CW    = NLIMB > 1 ? $clog2(NLIMB) : 1;
  localparam bit PAD   = EW > WIDTH;
  // Bit index of position WIDTH inside the extended sum (unused when no padding).
  localparam int WI    = PAD ? WIDTH : 0;

`ifdef MP_ADDSUB_SHIFT_EN
  typedef enum logic [1:0] {IDLE, RUN, SHIFT, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

  state_t          state_q, state_d;
  logic [EW-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            carry_q, carry_d, sub_q, sub_d, shf_q, shf_d;
  logic            cout_q, cout_d, zero_q, zero_d;
  logic [EW-1:0]   b_ext, res_next;
  logic [LIMB:0]   limb_sum;
  logic            mode_sub, mode_shf, last, cw_next, cw_cur;
  logic [WIDTH-1:0] shifted;

  assign mode_sub = mode == 2'b01;
`ifdef MP_ADDSUB_SHIFT_EN
  assign mode_shf = mode == 2'b10;
`else
  assign mode_shf = 1'b0;
`endif

  assign b_ext    = use_acc ? EW'(res_q[WIDTH-1:0]) : EW'(in_b);
  // Operands shift down one limb per cycle; the sum limb enters at the top of
  // the result, so after NLIMB steps every slice sits in its final position.
  assign limb_sum = {1'b0, a_q[LIMB-1:0]} + {1'b0, b_q[LIMB-1:0]} + {{LIMB{1'b0}}, carry_q};
  assign res_next = (res_q >> LIMB) | (EW'(limb_sum[LIMB-1:0]) << (EW - LIMB));
  assign last     = cnt_q == CW'(NLIMB - 1);
  // Carry into bit WIDTH: with padding it is sum[WIDTH] ^ a_ext[WIDTH] ^ b'_ext[WIDTH],
  // where a_ext[WIDTH]=0 and b'_ext[WIDTH] is 1 only for subtract.
  assign cw_next  = PAD ? res_next[WI] ^ sub_q : limb_sum[LIMB];
  assign cw_cur   = PAD ? res_q[WI] : carry_q;
  assign shifted  = {cw_cur, res_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    shf_d   = shf_q;
    cout_d  = cout_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        a_d     = EW'(in_a);
        b_d     = mode_sub ? ~b_ext : b_ext;
        sub_d   = mode_sub;
        shf_d   = mode_shf;
        carry_d = mode_sub;
        cnt_d   = '0;
      end
      RUN: begin
        a_d     = a_q >> LIMB;
        b_d     = b_q >> LIMB;
        res_d   = res_next;
        carry_d = limb_sum[LIMB];
        cnt_d   = cnt_q + 1'b1;
`ifdef MP_ADDSUB_SHIFT_EN
        if (last) state_d = shf_q ? SHIFT : DONE;
`else
        if (last) state_d = DONE;
`endif
        if (last && !shf_q) begin
          cout_d = cw_next;
          zero_d = res_next[WIDTH-1:0] == '0;
        end
      end
`ifdef MP_ADDSUB_SHIFT_EN
      SHIFT: begin
        res_d   = EW'(shifted);
        cout_d  = res_q[0];
        zero_d  = shifted == '0;
        state_d = DONE;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      shf_q   <= 1'b0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      shf_q   <= shf_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
    end
  end

  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = state_q == DONE;
  assign result    = res_q[WIDTH-1:0];
  assign carry_out = cout_q;
  assign zero      = zero_q;
endmodule
